// File: rtl/ccx_emem_responder.sv
// Responder end of the core complex emem_* bus modelling external memory at BASE:
// programmable wait states before grant, byte-strobed writes, registered response.
module ccx_emem_responder #(
    parameter int            AW          = 39,
    parameter int            DW          = 64,
    parameter logic [AW-1:0] BASE        = 39'h10000000,
    parameter int            DEPTH       = 1024,
    parameter int            WAIT_CYCLES = 0,
    parameter bit            EXEC_EN     = 1'b1,
    parameter bit            READ_ONLY   = 1'b0,
    parameter                MEMH        = "none"
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          stall,
    input  logic          mem_req,
    input  logic          mem_rtype,
    input  logic [AW-1:0] mem_addr,
    input  logic          mem_wen,
    input  logic [7:0]    mem_strb,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_err,
    output logic [DW-1:0] mem_rdata
);

    localparam int            IW     = $clog2(DEPTH);
    localparam logic [AW-1:0] SPAN   = AW'(DEPTH) << 3;
    localparam logic [3:0]    WAIT_N = 4'(WAIT_CYCLES);

    logic [3:0]    r_cnt;
    logic          r_err;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_mem [DEPTH];

    logic [AW-1:0] w_off;
    logic [IW-1:0] w_idx;
    logic          w_in_range;
    logic          w_err_next;
    logic          w_accept;
    logic          w_wr_en;

    // Offset wraps modulo 2^AW, so addresses below BASE need the explicit >= test.
    assign w_off      = mem_addr - BASE;
    assign w_in_range = (mem_addr >= BASE) && (w_off < SPAN);
    assign w_idx      = w_off[3 +: IW];
    assign w_err_next = !w_in_range || (mem_rtype && !EXEC_EN) || (mem_wen && READ_ONLY);

    // NOTE: grant is qualified by g_resetn so nothing is accepted or written while reset is held.
    assign mem_gnt  = g_resetn && mem_req && !stall && (r_cnt == WAIT_N);
    assign w_accept = mem_gnt;
    assign w_wr_en  = w_accept && mem_wen && !w_err_next;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_cnt <= 4'd0;
        end else if (!mem_req || w_accept) begin
            r_cnt <= 4'd0;
        end else if (!stall && (r_cnt != WAIT_N)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_err   <= w_err_next;
            r_rdata <= (w_err_next || mem_wen) ? '0 : r_mem[w_idx];
        end
    end

    // NOTE: the storage array has no reset; it keeps contents across g_resetn like real RAM.
    always_ff @(posedge g_clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < DW / 8; i++) begin
                if (mem_strb[i]) r_mem[w_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign mem_err   = r_err;
    assign mem_rdata = r_rdata;

endmodule

// File: tb/tb_ccx_emem_responder.sv
// Bench for ccx_emem_responder: four differently configured instances checked every
// cycle against a transaction-level model, plus hand-computed directed expectations.
module tb_ccx_emem_responder;

    localparam int          NL   = 4;
    localparam logic [38:0] BASE = 39'h10000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [NL];
    logic        rtype [NL];
    logic        wen   [NL];
    logic        stall [NL];
    logic [38:0] addr  [NL];
    logic [7:0]  strb  [NL];
    logic [63:0] wdata [NL];
    logic        gnt   [NL];
    logic        err   [NL];
    logic [63:0] rdata [NL];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Lane 0: WAIT 0, DEPTH 1024. Lane 1: WAIT 3. Lane 2: EXEC_EN=0. Lane 3: READ_ONLY=1.
    for (genvar g = 0; g < NL; g++) begin : g_dut
        ccx_emem_responder #(
            .BASE        (BASE),
            .DEPTH       (g == 0 ? 1024 : 16),
            .WAIT_CYCLES (g == 1 ? 3 : 0),
            .EXEC_EN     (g != 2),
            .READ_ONLY   (g == 3)
        ) u_dut (
            .g_clk     (clk),
            .g_resetn  (rst_n),
            .stall     (stall[g]),
            .mem_req   (req[g]),
            .mem_rtype (rtype[g]),
            .mem_addr  (addr[g]),
            .mem_wen   (wen[g]),
            .mem_strb  (strb[g]),
            .mem_wdata (wdata[g]),
            .mem_gnt   (gnt[g]),
            .mem_err   (err[g]),
            .mem_rdata (rdata[g])
        );
    end

    function automatic int wait_of(input int l);  return (l == 1) ? 3 : 0;     endfunction
    function automatic int depth_of(input int l); return (l == 0) ? 1024 : 16; endfunction
    function automatic bit exec_of(input int l);  return l != 2;               endfunction
    function automatic bit ro_of(input int l);    return l == 3;               endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_wait [NL];
    logic        m_err  [NL];
    logic [63:0] m_rd   [NL];
    bit          m_rk   [NL];
    logic        m_eg;
    logic [63:0] mmem [longint];
    logic [7:0]  mkn  [longint];

    task automatic model_accept(input int l);
        longint unsigned off;
        longint          key;
        bit              e;
        logic [63:0]     v;
        logic [7:0]      k;
        off = ({25'b0, addr[l]} - {25'b0, BASE}) & 64'h7F_FFFF_FFFF;
        e = (addr[l] < BASE) || (off >= longint'(depth_of(l) * 8)) ||
            (rtype[l] && !exec_of(l)) || (wen[l] && ro_of(l));
        key = longint'(l) * 65536 + longint'(off / 8);
        m_err[l] = e;
        m_rd[l]  = '0;
        m_rk[l]  = 1'b1;
        if (!e && wen[l]) begin
            v = mmem.exists(key) ? mmem[key] : '0;
            k = mkn.exists(key) ? mkn[key] : '0;
            for (int i = 0; i < 8; i++) begin
                if (strb[l][i]) begin
                    v[8*i +: 8] = wdata[l][8*i +: 8];
                    k[i] = 1'b1;
                end
            end
            mmem[key] = v;
            mkn[key]  = k;
        end else if (!e) begin
            m_rd[l] = mmem.exists(key) ? mmem[key] : '0;
            m_rk[l] = mkn.exists(key) && (mkn[key] == 8'hFF);
        end
    endtask

    always @(negedge clk) begin
        for (int l = 0; l < NL; l++) begin
            if (!rst_n) begin
                m_wait[l] = 0;
                m_err[l]  = 1'b0;
                m_rd[l]   = '0;
                m_rk[l]   = 1'b1;
                check($sformatf("lane%0d reset gnt", l), 64'(gnt[l]), 64'd0);
                check($sformatf("lane%0d reset err", l), 64'(err[l]), 64'd0);
                check($sformatf("lane%0d reset rdata", l), rdata[l], 64'd0);
            end else begin
                m_eg = req[l] && !stall[l] && (m_wait[l] >= wait_of(l));
                check($sformatf("lane%0d gnt", l), 64'(gnt[l]), 64'(m_eg));
                check($sformatf("lane%0d err", l), 64'(err[l]), 64'(m_err[l]));
                if (m_rk[l]) check($sformatf("lane%0d rdata", l), rdata[l], m_rd[l]);
                if (m_eg) begin
                    model_accept(l);
                    m_wait[l] = 0;
                end else if (!req[l]) begin
                    m_wait[l] = 0;
                end else if (!stall[l]) begin
                    m_wait[l]++;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Starts at posedge+1; returns the cycle (from 0) in which gnt was seen and the response.
    task automatic xact(input int l, input logic rt, input logic [38:0] a, input logic we,
                        input logic [7:0] sb, input logic [63:0] wd, input int ss, input int sl,
                        output int gc, output logic e, output logic [63:0] rd);
        int c;
        bit done;
        gc = -1;
        c = 0;
        done = 1'b0;
        req[l] = 1'b1; rtype[l] = rt; addr[l] = a; wen[l] = we; strb[l] = sb; wdata[l] = wd;
        while (!done && c < 40) begin
            stall[l] = (c >= ss) && (c < ss + sl);
            @(negedge clk);
            if (gnt[l]) begin
                gc = c;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            c++;
        end
        req[l] = 1'b0; wen[l] = 1'b0; rtype[l] = 1'b0; stall[l] = 1'b0;
        e  = err[l];
        rd = rdata[l];
        check("gnt_timeout", 64'(done), 64'd1);
    endtask

    task automatic expect_rsp(input string name, input int gc, input logic e, input logic [63:0] rd,
                              input int egc, input logic ee, input logic [63:0] erd);
        check({name, " gnt_cycle"}, 64'(gc), 64'(egc));
        check({name, " err"}, 64'(e), 64'(ee));
        check({name, " rdata"}, rd, erd);
    endtask

    initial begin
        int          gc;
        logic        e;
        logic [63:0] rd;
        for (int l = 0; l < NL; l++) begin
            req[l] = 1'b0; rtype[l] = 1'b0; wen[l] = 1'b0; stall[l] = 1'b0;
            addr[l] = '0; strb[l] = '0; wdata[l] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("por gnt", 64'(gnt[0]), 64'd0);
        check("por err", 64'(err[0]), 64'd0);
        check("por rdata", rdata[0], 64'd0);
        rst_n = 1'b1;

        // Lane 0: zero wait, full/partial writes, address decode boundaries.
        xact(0, 0, BASE + 39'h8, 1, 8'hFF, 64'h1122334455667788, 99, 0, gc, e, rd);
        expect_rsp("wr w1", gc, e, rd, 0, 0, 64'h0);
        xact(0, 0, BASE + 39'h8, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("rd w1", gc, e, rd, 0, 0, 64'h1122334455667788);
        xact(0, 0, BASE, 1, 8'hFF, 64'h0, 99, 0, gc, e, rd);
        xact(0, 0, BASE, 1, 8'h0F, 64'hAAAAAAAABBBBBBBB, 99, 0, gc, e, rd);
        xact(0, 0, BASE, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("partial strb", gc, e, rd, 0, 0, 64'h00000000BBBBBBBB);
        xact(0, 0, BASE + 39'hD, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("low bits ignored", gc, e, rd, 0, 0, 64'h1122334455667788);
        xact(0, 0, BASE + 39'h2000, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("rd above top", gc, e, rd, 0, 1, 64'h0);
        xact(0, 0, 39'h0FFFFFF8, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("rd below base", gc, e, rd, 0, 1, 64'h0);
        xact(0, 0, BASE + 39'h2000, 1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 99, 0, gc, e, rd);
        expect_rsp("wr above top", gc, e, rd, 0, 1, 64'h0);
        xact(0, 0, BASE, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("w0 unchanged", gc, e, rd, 0, 0, 64'h00000000BBBBBBBB);
        xact(0, 0, BASE + 39'h1FF8, 1, 8'hFF, 64'h0BADF00D12345678, 99, 0, gc, e, rd);
        xact(0, 0, BASE + 39'h1FF8, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("last word", gc, e, rd, 0, 0, 64'h0BADF00D12345678);
        xact(0, 0, BASE + 39'h8, 1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 99, 0, gc, e, rd);
        expect_rsp("strb0 wr", gc, e, rd, 0, 0, 64'h0);
        xact(0, 0, BASE + 39'h8, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("strb0 rd", gc, e, rd, 0, 0, 64'h1122334455667788);

        // Lane 1: three wait states, stall, abandoned request, reset mid-wait.
        xact(1, 0, BASE, 1, 8'hFF, 64'h0123456789ABCDEF, 99, 0, gc, e, rd);
        expect_rsp("wait3 wr", gc, e, rd, 3, 0, 64'h0);
        xact(1, 0, BASE, 0, 8'h00, 64'h0, 2, 2, gc, e, rd);
        expect_rsp("wait3 stall rd", gc, e, rd, 5, 0, 64'h0123456789ABCDEF);
        req[1] = 1'b1; wen[1] = 1'b1; addr[1] = BASE; strb[1] = 8'hFF; wdata[1] = '1;
        repeat (2) @(posedge clk);
        #1;
        req[1] = 1'b0; wen[1] = 1'b0;
        @(posedge clk);
        #1;
        xact(1, 0, BASE, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("dropped req", gc, e, rd, 3, 0, 64'h0123456789ABCDEF);
        req[1] = 1'b1; wen[1] = 1'b1; addr[1] = BASE + 39'h8; strb[1] = 8'hFF;
        wdata[1] = 64'h5555AAAA5555AAAA;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst gnt", 64'(gnt[1]), 64'd0);
        check("rst err", 64'(err[1]), 64'd0);
        check("rst rdata", rdata[1], 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        xact(1, 0, BASE + 39'h8, 1, 8'hFF, 64'h5555AAAA5555AAAA, 99, 0, gc, e, rd);
        expect_rsp("post-reset wr", gc, e, rd, 3, 0, 64'h0);
        xact(1, 0, BASE + 39'h8, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("post-reset rd", gc, e, rd, 3, 0, 64'h5555AAAA5555AAAA);
        xact(0, 0, BASE + 39'h8, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("mem kept over reset", gc, e, rd, 0, 0, 64'h1122334455667788);

        // Lane 2: instruction fetches rejected.
        xact(2, 0, BASE + 39'h10, 1, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 99, 0, gc, e, rd);
        xact(2, 0, BASE + 39'h10, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("noexec data rd", gc, e, rd, 0, 0, 64'h0F0F0F0F0F0F0F0F);
        xact(2, 1, BASE + 39'h10, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        expect_rsp("noexec fetch", gc, e, rd, 0, 1, 64'h0);

        // Lane 3: writes rejected and must not land.
        xact(3, 0, BASE + 39'h18, 1, 8'hFF, 64'hDEADBEEFCAFEF00D, 99, 0, gc, e, rd);
        expect_rsp("ro wr", gc, e, rd, 0, 1, 64'h0);
        xact(3, 0, BASE + 39'h18, 0, 8'h00, 64'h0, 99, 0, gc, e, rd);
        check("ro rd err", 64'(e), 64'd0);
        check("ro mem untouched", 64'(rd == 64'hDEADBEEFCAFEF00D), 64'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
